// File: rtl/compuertas_pkg.sv
// Shared definitions for the gate-unit sweep checker: FSM states,
// bit positions of the gate result vector and the reference truth table.
package compuertas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int unsigned NUM_GATES = 7;

    localparam int unsigned AND_B  = 0;
    localparam int unsigned NAND_B = 1;
    localparam int unsigned OR_B   = 2;
    localparam int unsigned NOR_B  = 3;
    localparam int unsigned NOTA_B = 4;
    localparam int unsigned XOR_B  = 5;
    localparam int unsigned XNOR_B = 6;

    // Reference outputs of a correct gate unit for operands (a, b)
    function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
        logic [NUM_GATES-1:0] e;
        e         = '0;
        e[AND_B]  = a & b;
        e[NAND_B] = ~(a & b);
        e[OR_B]   = a | b;
        e[NOR_B]  = ~(a | b);
        e[NOTA_B] = ~a;
        e[XOR_B]  = a ^ b;
        e[XNOR_B] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/compuertas_esperado.sv
// Combinational expected-value generator for the gate unit.
module compuertas_esperado
    import compuertas_pkg::*;
(
    input  logic                 a_i,
    input  logic                 b_i,
    output logic [NUM_GATES-1:0] exp_o
);

    // Truth table lookup for the operands currently driven
    always_comb begin
        exp_o = expected_gates(a_i, b_i);
    end

endmodule

// File: rtl/compuertas_barrido.sv
// Sweep-and-check self-test for the two-input gate unit: drives all four
// operand pairs, samples the seven gate outputs after HOLD_CYCLES settle
// cycles and accumulates a sticky per-gate error mask.
// Optional raw-result log enabled by defining COMPUERTAS_BARRIDO_LOG_EN.
module compuertas_barrido
    import compuertas_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    input  logic [NUM_GATES-1:0] res,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] err_mask,
    output logic [1:0]           vec_idx,
    input  logic [1:0]           rd_idx,
    output logic [NUM_GATES-1:0] rd_data
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t               state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic [1:0]           vec_q, vec_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic [NUM_GATES-1:0] mask_q, mask_d;
    logic                 pass_q, pass_d;
    logic                 log_we;
    logic                 log_clr;
    logic [NUM_GATES-1:0] exp_w;

    compuertas_esperado u_esperado (
        .a_i   (a_q),
        .b_i   (b_q),
        .exp_o (exp_w)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            vec_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, operand sequencing and mismatch accumulation
    always_comb begin
        logic [NUM_GATES-1:0] mask_next;
        logic [1:0]           vec_next;
        state_d   = state_q;
        hold_d    = hold_q;
        vec_d     = vec_q;
        a_d       = a_q;
        b_d       = b_q;
        mask_d    = mask_q;
        pass_d    = pass_q;
        log_we    = 1'b0;
        log_clr   = 1'b0;
        mask_next = mask_q | (res ^ exp_w);
        vec_next  = vec_q + 2'd1;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                vec_d  = '0;
                a_d    = 1'b0;
                b_d    = 1'b0;
                // mask and pass survive IDLE so the result stays readable
                if (start) begin
                    state_d = ST_DRIVE;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    log_clr = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                mask_d = mask_next;
                log_we = 1'b1;
                if (vec_q == 2'd3) begin
                    state_d = ST_DONE;
                    pass_d  = ~|mask_next;
                    vec_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_next;
                    a_d     = vec_next[1];
                    b_d     = vec_next[0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign err_mask = mask_q;
    assign vec_idx  = vec_q;

`ifdef COMPUERTAS_BARRIDO_LOG_EN
    logic [NUM_GATES-1:0] log_q [4];

    // Raw result log, one entry per vector, cleared on reset and new sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) log_q[i] <= '0;
        end else if (log_clr) begin
            for (int unsigned i = 0; i < 4; i++) log_q[i] <= '0;
        end else if (log_we) begin
            log_q[vec_q] <= res;
        end
    end

    assign rd_data = log_q[rd_idx];
`else
    logic unused_log;
    assign unused_log = ^{rd_idx, log_we, log_clr};
    assign rd_data    = '0;
`endif

endmodule
